// File: rtl/stopwatch_timer.sv
// stopwatch_timer: BCD up/down stopwatch (M:T:O.t) for the seven-segment display path.
// Counts in tenth-second ticks, flashes the display at the terminal value, and
// supports a lap freeze of the displayed value while counting continues.
// Ports:
//   clk, reset (async, active-low)
//   Start/Stop/Clear/Lap   level inputs, rising edge acts
//   Countdown              mode select on Start from IDLE/FLASH (1 = down)
//   Preset_*               count-down start value (saturated per digit)
//   Minutes..Tenths_Seconds displayed BCD digits
//   Running, Flashing, Anode_En, Done  status / display enable
module stopwatch_timer #(
  parameter int unsigned TICK_DIV    = 10_000_000,
  parameter int unsigned MAX_MINUTES = 9,
  parameter int unsigned FLASH_TICKS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Start,
  input  logic       Stop,
  input  logic       Clear,
  input  logic       Lap,
  input  logic       Countdown,
  input  logic [3:0] Preset_Minutes,
  input  logic [3:0] Preset_Tens,
  input  logic [3:0] Preset_Ones,
  input  logic [3:0] Preset_Tenths,
  output logic [3:0] Minutes,
  output logic [3:0] Tens_Seconds,
  output logic [3:0] Ones_Seconds,
  output logic [3:0] Tenths_Seconds,
  output logic       Running,
  output logic       Flashing,
  output logic       Anode_En,
  output logic       Done
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned FW = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
  localparam int unsigned CW = 16;
  localparam logic [3:0]    MAX_MIN   = 4'(MAX_MINUTES);
  localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FLASH_TOP = FW'(FLASH_TICKS - 1);
  localparam logic [CW-1:0] TERM_UP   = {MAX_MIN, 4'd5, 4'd9, 4'd9};
  localparam logic [CW-1:0] TERM_DN   = '0;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_FLASH} state_e;

  state_e          state_q, state_d;
  logic            start_q, stop_q, clear_q, lap_q;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   snap_q, snap_d;
  logic [CW-1:0]   disp_q, disp_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic            mode_q, mode_d;
  logic            freeze_q, freeze_d;
  logic            running_q, running_d;
  logic            flashing_q, flashing_d;
  logic            anode_q, anode_d;
  logic            done_q, done_d;

  logic            start_e, stop_e, clear_e, lap_e;
  logic            start_act, stop_act;
  logic            tick, load_start, flash_entry, flash_wrap;
  logic [CW-1:0]   preset_sat, term, count_step;

  // BCD increment with carry: tenths 9->0, ones 9->0, tens 5->0 into minutes
  function automatic logic [CW-1:0] bcd_up(input logic [CW-1:0] c);
    logic [3:0] m, t, o, d;
    {m, t, o, d} = c;
    if (d != 4'd9) d = d + 4'd1;
    else begin
      d = 4'd0;
      if (o != 4'd9) o = o + 4'd1;
      else begin
        o = 4'd0;
        if (t != 4'd5) t = t + 4'd1;
        else begin
          t = 4'd0;
          m = m + 4'd1;
        end
      end
    end
    return {m, t, o, d};
  endfunction

  // BCD decrement with borrow, mirror image of bcd_up
  function automatic logic [CW-1:0] bcd_dn(input logic [CW-1:0] c);
    logic [3:0] m, t, o, d;
    {m, t, o, d} = c;
    if (d != 4'd0) d = d - 4'd1;
    else begin
      d = 4'd9;
      if (o != 4'd0) o = o - 4'd1;
      else begin
        o = 4'd9;
        if (t != 4'd0) t = t - 4'd1;
        else begin
          t = 4'd5;
          m = m - 4'd1;
        end
      end
    end
    return {m, t, o, d};
  endfunction

  assign start_e   = Start & ~start_q;
  assign stop_e    = Stop  & ~stop_q;
  assign clear_e   = Clear & ~clear_q;
  assign lap_e     = Lap   & ~lap_q;
  // Clear beats Stop beats Start
  assign stop_act  = stop_e & ~clear_e;
  assign start_act = start_e & ~stop_e & ~clear_e;

  assign tick = (presc_q == PRESC_TOP);

  assign preset_sat = {(Preset_Minutes > MAX_MIN) ? MAX_MIN : Preset_Minutes,
                       (Preset_Tens    > 4'd5)    ? 4'd5    : Preset_Tens,
                       (Preset_Ones    > 4'd9)    ? 4'd9    : Preset_Ones,
                       (Preset_Tenths  > 4'd9)    ? 4'd9    : Preset_Tenths};

  // A step from the terminal value holds there (possible after FLASH->PAUSED->RUN)
  assign term       = mode_q ? TERM_DN : TERM_UP;
  assign count_step = (count_q == term) ? count_q : (mode_q ? bcd_dn(count_q) : bcd_up(count_q));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; load_start marks a fresh start (count cleared or preset loaded)
  always_comb begin
    state_d    = state_q;
    load_start = 1'b0;
    unique case (state_q)
      S_IDLE: if (start_act) load_start = 1'b1;
      S_RUN: begin
        if (clear_e)                          state_d = S_IDLE;
        else if (tick && count_step == term)  state_d = S_FLASH;
        else if (stop_act)                    state_d = S_PAUSED;
      end
      S_PAUSED: begin
        if (clear_e)        state_d = S_IDLE;
        else if (start_act) state_d = S_RUN;
      end
      S_FLASH: begin
        if (clear_e)        state_d = S_IDLE;
        else if (stop_act)  state_d = S_PAUSED;
        else if (start_act) load_start = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (load_start) state_d = (Countdown && preset_sat == '0) ? S_FLASH : S_RUN;
  end

  assign flash_entry = (state_d == S_FLASH) && ((state_q != S_FLASH) || load_start);
  assign flash_wrap  = (state_q == S_FLASH) && (state_d == S_FLASH) && !flash_entry &&
                       tick && (fcnt_q == FLASH_TOP);

  // Datapath next values: count, prescaler, mode, lap freeze, display
  always_comb begin
    count_d  = count_q;
    presc_d  = presc_q;
    mode_d   = mode_q;
    snap_d   = snap_q;
    freeze_d = freeze_q;
    fcnt_d   = fcnt_q;
    if (clear_e) begin
      count_d = '0;
      presc_d = '0;
    end else if (load_start) begin
      mode_d  = Countdown;
      count_d = Countdown ? preset_sat : '0;
      presc_d = '0;
    end else if (state_q == S_RUN || state_q == S_FLASH) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (state_q == S_RUN && tick) count_d = count_step;
    end

    if (flash_entry)     fcnt_d = '0;
    else if (flash_wrap) fcnt_d = '0;
    else if (state_q == S_FLASH && state_d == S_FLASH && tick) fcnt_d = fcnt_q + FW'(1);

    if (clear_e || flash_entry) freeze_d = 1'b0;
    else if (lap_e && (state_q == S_RUN || state_q == S_PAUSED)) begin
      freeze_d = ~freeze_q;
      if (!freeze_q) snap_d = count_q;
    end

    disp_d = freeze_d ? snap_d : count_d;
  end

  // Output logic (registered below)
  always_comb begin
    running_d  = (state_d == S_RUN);
    flashing_d = (state_d == S_FLASH);
    done_d     = flash_entry;
    anode_d    = 1'b1;
    if (flash_entry)             anode_d = 1'b0;
    else if (state_d == S_FLASH) anode_d = flash_wrap ? ~anode_q : anode_q;
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      clear_q    <= 1'b0;
      lap_q      <= 1'b0;
      count_q    <= '0;
      snap_q     <= '0;
      disp_q     <= '0;
      presc_q    <= '0;
      fcnt_q     <= '0;
      mode_q     <= 1'b0;
      freeze_q   <= 1'b0;
      running_q  <= 1'b0;
      flashing_q <= 1'b0;
      anode_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      start_q    <= Start;
      stop_q     <= Stop;
      clear_q    <= Clear;
      lap_q      <= Lap;
      count_q    <= count_d;
      snap_q     <= snap_d;
      disp_q     <= disp_d;
      presc_q    <= presc_d;
      fcnt_q     <= fcnt_d;
      mode_q     <= mode_d;
      freeze_q   <= freeze_d;
      running_q  <= running_d;
      flashing_q <= flashing_d;
      anode_q    <= anode_d;
      done_q     <= done_d;
    end
  end

  assign {Minutes, Tens_Seconds, Ones_Seconds, Tenths_Seconds} = disp_q;
  assign Running  = running_q;
  assign Flashing = flashing_q;
  assign Anode_En = anode_q;
  assign Done     = done_q;

endmodule

// File: tb/tb_stopwatch_timer.sv
// Testbench for stopwatch_timer: directed scenarios plus randomized stimulus,
// checked every cycle against a reference model that tracks time as an
// integer count of tenths.
module tb_stopwatch_timer;

  localparam int TD = 2;
  localparam int MM = 1;
  localparam int FT = 2;
  localparam int ST_IDLE  = 0;
  localparam int ST_RUN   = 1;
  localparam int ST_PAUSE = 2;
  localparam int ST_FLASH = 3;
  localparam int TERM_UP  = MM * 600 + 599;

  logic       clk = 1'b0;
  logic       reset;
  logic       Start, Stop, Clear, Lap, Countdown;
  logic [3:0] Preset_Minutes, Preset_Tens, Preset_Ones, Preset_Tenths;
  logic [3:0] Minutes, Tens_Seconds, Ones_Seconds, Tenths_Seconds;
  logic       Running, Flashing, Anode_En, Done;

  stopwatch_timer #(.TICK_DIV(TD), .MAX_MINUTES(MM), .FLASH_TICKS(FT)) dut (
    .clk(clk), .reset(reset),
    .Start(Start), .Stop(Stop), .Clear(Clear), .Lap(Lap), .Countdown(Countdown),
    .Preset_Minutes(Preset_Minutes), .Preset_Tens(Preset_Tens),
    .Preset_Ones(Preset_Ones), .Preset_Tenths(Preset_Tenths),
    .Minutes(Minutes), .Tens_Seconds(Tens_Seconds),
    .Ones_Seconds(Ones_Seconds), .Tenths_Seconds(Tenths_Seconds),
    .Running(Running), .Flashing(Flashing), .Anode_En(Anode_En), .Done(Done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: time held as integer tenths
  int m_state, m_val, m_ph, m_fl, m_snap;
  bit m_down, m_anode, m_done, m_frz, m_entry;
  bit p_start, p_stop, p_clear, p_lap;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int sat_preset();
    return imin(int'(Preset_Minutes), MM) * 600 + imin(int'(Preset_Tens), 5) * 100 +
           imin(int'(Preset_Ones), 9) * 10 + imin(int'(Preset_Tenths), 9);
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 600), 4'((v % 600) / 100), 4'((v % 100) / 10), 4'(v % 10)};
  endfunction

  function automatic void model_reset();
    m_state = ST_IDLE; m_val = 0; m_ph = 0; m_fl = 0; m_snap = 0;
    m_down = 0; m_anode = 1; m_done = 0; m_frz = 0; m_entry = 0;
    p_start = 0; p_stop = 0; p_clear = 0; p_lap = 0;
  endfunction

  function automatic void enter_flash();
    m_state = ST_FLASH; m_done = 1; m_anode = 0; m_fl = 0; m_entry = 1;
  endfunction

  function automatic void do_start();
    m_down = Countdown;
    m_ph   = 0;
    m_val  = Countdown ? sat_preset() : 0;
    if (Countdown && m_val == 0) enter_flash();
    else m_state = ST_RUN;
  endfunction

  function automatic void do_clear();
    m_state = ST_IDLE; m_val = 0; m_ph = 0;
  endfunction

  function automatic void model_step();
    bit se, te, ce, le, stp, sta, tk;
    int old_state, old_val, term;
    se = Start && !p_start; te = Stop && !p_stop; ce = Clear && !p_clear; le = Lap && !p_lap;
    p_start = Start; p_stop = Stop; p_clear = Clear; p_lap = Lap;
    stp = te && !ce;
    sta = se && !te && !ce;
    m_done = 0; m_entry = 0;
    old_state = m_state; old_val = m_val;
    term = m_down ? 0 : TERM_UP;
    tk = 0;
    if ((m_state == ST_RUN || m_state == ST_FLASH) && !ce) begin
      m_ph++;
      if (m_ph == TD) begin m_ph = 0; tk = 1; end
    end
    case (m_state)
      ST_IDLE: if (sta) do_start();
      ST_RUN: begin
        if (ce) do_clear();
        else begin
          if (tk && m_val != term) m_val += m_down ? -1 : 1;
          if (tk && m_val == term) enter_flash();
          else if (stp) m_state = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (ce) do_clear();
        else if (sta) m_state = ST_RUN;
      end
      ST_FLASH: begin
        if (ce) do_clear();
        else if (stp) m_state = ST_PAUSE;
        else if (sta) do_start();
        else if (tk) begin
          m_fl++;
          if (m_fl == FT) begin m_fl = 0; m_anode = !m_anode; end
        end
      end
      default: m_state = ST_IDLE;
    endcase
    if (m_state != ST_FLASH) m_anode = 1;
    if (ce || m_entry) m_frz = 0;
    else if (le && (old_state == ST_RUN || old_state == ST_PAUSE)) begin
      if (!m_frz) m_snap = old_val;
      m_frz = !m_frz;
    end
  endfunction

  // One clock: advance model at the edge, compare 1 time unit later
  task automatic cyc();
    logic [3:0] exp_flags;
    @(posedge clk);
    model_step();
    #1;
    exp_flags = {m_state == ST_RUN, m_state == ST_FLASH, m_anode, m_done};
    check("digits", 32'({Minutes, Tens_Seconds, Ones_Seconds, Tenths_Seconds}),
          32'(to_bcd(m_frz ? m_snap : m_val)));
    check("flags", 32'({Running, Flashing, Anode_En, Done}), 32'(exp_flags));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Assert reset between edges and verify outputs without any clock edge
  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    check({tag, "_digits"}, 32'({Minutes, Tens_Seconds, Ones_Seconds, Tenths_Seconds}), 32'h0);
    check({tag, "_flags"}, 32'({Running, Flashing, Anode_En, Done}), 32'b0010);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic set_preset(input logic [3:0] m, input logic [3:0] t,
                            input logic [3:0] o, input logic [3:0] d);
    Preset_Minutes = m; Preset_Tens = t; Preset_Ones = o; Preset_Tenths = d;
  endtask

  task automatic pulse_clear();
    Clear = 1'b1; cyc(); Clear = 1'b0; cyc();
  endtask

  initial begin
    reset = 1'b0;
    Start = 0; Stop = 0; Clear = 0; Lap = 0; Countdown = 0;
    set_preset(4'd0, 4'd0, 4'd0, 4'd0);
    model_reset();
    #12;
    check("reset_digits", 32'({Minutes, Tens_Seconds, Ones_Seconds, Tenths_Seconds}), 32'h0);
    check("reset_flags", 32'({Running, Flashing, Anode_En, Done}), 32'b0010);
    @(negedge clk);
    reset = 1'b1;
    cycles(2);

    // Count up to terminal
    Countdown = 1'b0; Start = 1'b1; cyc(); Start = 1'b0; cycles(2);
    check("up_first_tick", 32'({Minutes, Tens_Seconds, Ones_Seconds, Tenths_Seconds}), 32'h0001);
    cycles(2396);
    check("up_terminal", 32'({Minutes, Tens_Seconds, Ones_Seconds, Tenths_Seconds}), 32'h1599);
    check("up_flash_entry", 32'({Running, Flashing, Anode_En, Done}), 32'b0101);
    cycles(12);
    pulse_clear();

    // Count-down with saturated preset
    Countdown = 1'b1; set_preset(4'd0, 4'd0, 4'd1, 4'hF);
    Start = 1'b1; cyc(); Start = 1'b0;
    check("preset_sat", 32'({Minutes, Tens_Seconds, Ones_Seconds, Tenths_Seconds}), 32'h0019);
    cycles(42);

    // Zero preset: straight to FLASH from FLASH and from IDLE
    set_preset(4'd0, 4'd0, 4'd0, 4'd0);
    Start = 1'b1; cyc(); Start = 1'b0;
    check("zero_from_flash", 32'({Running, Flashing, Anode_En, Done}), 32'b0101);
    cycles(3);
    pulse_clear();
    Start = 1'b1; cyc(); Start = 1'b0;
    check("zero_from_idle", 32'({Running, Flashing, Anode_En, Done}), 32'b0101);
    cycles(3);
    pulse_clear();

    // Pause / resume, Countdown change ignored while paused
    Countdown = 1'b0; Start = 1'b1; cyc(); Start = 1'b0; cycles(4);
    Stop = 1'b1; cyc(); Stop = 1'b0; Countdown = 1'b1; cycles(20);
    Start = 1'b1; cyc(); Start = 1'b0; cycles(8);

    // Simultaneous edges
    Start = 1'b1; Stop = 1'b1; Clear = 1'b1; cyc();
    Start = 1'b0; Stop = 1'b0; Clear = 1'b0; cycles(2);
    Countdown = 1'b0; Start = 1'b1; cyc(); Start = 1'b0; cycles(3);
    Start = 1'b1; Stop = 1'b1; cyc(); Start = 1'b0; Stop = 1'b0; cycles(6);
    pulse_clear();

    // Lap freeze and release
    Countdown = 1'b0; Start = 1'b1; cyc(); Start = 1'b0; cycles(6);
    Lap = 1'b1; cyc(); Lap = 1'b0; cycles(9);
    Lap = 1'b1; cyc(); Lap = 1'b0; cycles(4);
    pulse_clear();

    // Lap frozen across FLASH entry
    Countdown = 1'b1; set_preset(4'd0, 4'd0, 4'd0, 4'd5);
    Start = 1'b1; cyc(); Start = 1'b0; cyc();
    Lap = 1'b1; cyc(); Lap = 1'b0; cycles(14);

    // Async reset mid-FLASH, then a normal start
    async_reset("rst_flash");
    Countdown = 1'b0; Start = 1'b1; cyc(); Start = 1'b0; cycles(10);

    // Randomized stimulus
    for (int i = 0; i < 16000; i++) begin
      Start = ($urandom_range(0, 7) == 0);
      Stop  = ($urandom_range(0, 29) == 0);
      Clear = ($urandom_range(0, 199) == 0);
      Lap   = ($urandom_range(0, 39) == 0);
      Countdown = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0)
        set_preset(($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd0,
                   ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0,
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      cyc();
      if (i % 5000 == 2500) async_reset("rst_rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
